pipe_reg_gen: RTL

PIPE_REG_GEN -- requirements
Module: pipe_reg_gen

---
 rtl/pipe_reg_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_reg_gen.sv
// pipe_reg_gen: parameterised-depth pipeline register for the MEM/WB path.
// Each stage carries a valid bit, write-back/memory-read flags, ALU result,
// memory read data and destination register. The block supports whole-pipe
// freeze and flush. Hazard queries look at every stage. A saturating counter
// records the number of frozen cycles.
module pipe_reg_gen #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              WB_en_in,
  input  logic              MEM_R_en_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] Mem_read_value_in,
  input  logic [DEST_W-1:0] Dest_in,
  input  logic [DEST_W-1:0] query_src1,
  input  logic [DEST_W-1:0] query_src2,
  output logic              valid,
  output logic              WB_en,
  output logic              MEM_R_en,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] Mem_read_value,
  output logic [DEST_W-1:0] Dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              hit1,
  output logic              hit2,
  output logic [15:0]       freeze_cnt
);

  // Reject unsupported depths at elaboration time.
  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
      $error("pipe_reg_gen: DEPTH must be within 1..4");
    end
  endgenerate

  // Per-stage contents; index 0 is the input stage and DEPTH-1 drives the outputs.
  logic              stg_vld  [DEPTH];
  logic              stg_wb   [DEPTH];
  logic              stg_mr   [DEPTH];
  logic [DATA_W-1:0] stg_alu  [DEPTH];
  logic [DATA_W-1:0] stg_mem  [DEPTH];
  logic [DEST_W-1:0] stg_dest [DEPTH];

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // True when a stage would write back to a nonzero register matching the query.
  function automatic logic stage_hit(input logic vld, input logic wb,
                                     input logic [DEST_W-1:0] dest,
                                     input logic [DEST_W-1:0] query);
    return vld && wb && (dest != '0) && (dest == query);
  endfunction

  // Stage shift. Flush kills valid/WB_en but leaves the data untouched.
  // Freeze holds every stage. A bubble input never carries a write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_vld[k]  <= 1'b0;
        stg_wb[k]   <= 1'b0;
        stg_mr[k]   <= 1'b0;
        stg_alu[k]  <= '0;
        stg_mem[k]  <= '0;
        stg_dest[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_vld[k] <= 1'b0;
        stg_wb[k]  <= 1'b0;
      end
    end else if (!freeze) begin
      // ---- stage 0: capture inputs ----
      stg_vld[0]  <= in_valid;
      stg_wb[0]   <= WB_en_in & in_valid;
      stg_mr[0]   <= MEM_R_en_in;
      stg_alu[0]  <= ALU_result_in;
      stg_mem[0]  <= Mem_read_value_in;
      stg_dest[0] <= Dest_in;
      // ---- stage k: capture stage k-1 ----
      for (int k = 1; k < DEPTH; k++) begin
        stg_vld[k]  <= stg_vld[k-1];
        stg_wb[k]   <= stg_wb[k-1];
        stg_mr[k]   <= stg_mr[k-1];
        stg_alu[k]  <= stg_alu[k-1];
        stg_mem[k]  <= stg_mem[k-1];
        stg_dest[k] <= stg_dest[k-1];
      end
    end
  end

  // Count frozen cycles. A flush edge is not a frozen edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_cnt <= 16'h0000;
    end else if (freeze && !flush) begin
      freeze_cnt <= sat_inc16(freeze_cnt);
    end
  end

  // ---- output stage: flags gated by valid, write-back mux ----
  assign valid          = stg_vld[DEPTH-1];
  assign WB_en          = stg_wb[DEPTH-1] & stg_vld[DEPTH-1];
  assign MEM_R_en       = stg_mr[DEPTH-1] & stg_vld[DEPTH-1];
  assign ALU_result     = stg_alu[DEPTH-1];
  assign Mem_read_value = stg_mem[DEPTH-1];
  assign Dest           = stg_dest[DEPTH-1];
  assign wb_data        = MEM_R_en ? Mem_read_value : ALU_result;

  // Hazard detection across every in-flight stage.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (stage_hit(stg_vld[k], stg_wb[k], stg_dest[k], query_src1)) hit1 = 1'b1;
      if (stage_hit(stg_vld[k], stg_wb[k], stg_dest[k], query_src2)) hit2 = 1'b1;
    end
  end

endmodule
